// File: rtl/lfsr.sv
// 128-bit Fibonacci LFSR (x^128+x^126+x^101+x^99+1) advancing NBITS steps per clock.
// q exposes the NBITS most recent feedback bits straight from the state register.
module lfsr #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [127:0]     data,
    output logic [NBITS-1:0] q
);

    logic [127:0] state;
    logic [127:0] stepped;
    logic [127:0] seed;

    // Unrolled chain: each step feeds on the previous step's result, so after
    // NBITS steps the low NBITS bits hold the feedback bits, newest at bit 0.
    always_comb begin
        stepped = state;
        for (int unsigned i = 0; i < NBITS; i++) begin
            stepped = {stepped[126:0],
                       stepped[127] ^ stepped[125] ^ stepped[100] ^ stepped[98]};
        end
    end

    // An all-zero seed would lock the register; substitute the reset value.
    assign seed = (data == '0) ? 128'd1 : data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= 128'd1;
        end else if (we) begin
            state <= seed;
        end else begin
            state <= stepped;
        end
    end

    assign q = state[NBITS-1:0];

endmodule

// File: tb/tb_lfsr.sv
// Scoreboard bench for lfsr (NBITS=16): stimulus queues expected state/q per cycle,
// a monitor compares on the falling edge after the rising edge that produced them.
module tb_lfsr;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [127:0] data;
    logic [15:0]  q;

    lfsr #(.NBITS(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .data (data),
        .q    (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        string        name;
        logic [15:0]  q;
        logic [127:0] st;
    } exp_t;

    exp_t         sb[$];
    int           cycle  = 0;
    int           checks = 0;
    int           passed = 0;
    logic [127:0] m;

    localparam logic [127:0] D1 = 128'h11112222333344445555666677778888;
    localparam logic [127:0] D2 = 128'h9999aaaabbbbccccddddeeeeffff0000;

    always @(posedge clk) cycle <= cycle + 1;

    // 16 steps in closed form: step k's feedback only sees original bits since 98-15 >= 0.
    function automatic logic [127:0] step16(input logic [127:0] s);
        logic [15:0] f;
        f = s[127:112] ^ s[125:110] ^ s[100:85] ^ s[98:83];
        return {s[111:0], f};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push(input int cyc, input string name, input logic [127:0] st);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.q    = st[15:0];
        e.st   = st;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic w, input logic [127:0] d,
                         input string name, input logic [127:0] exp_st);
        @(negedge clk);
        #1;
        rst  = r;
        we   = w;
        data = d;
        m    = exp_st;
        push(cycle + 1, name, exp_st);
    endtask

    task automatic run_free(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, rnd128(), name, step16(m));
        end
    endtask

    // Monitor: consume every expectation that targets the edge just completed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cycle) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc < cycle) begin
                    $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cycle);
                end else if (q === e.q) begin
                    passed++;
                end else begin
                    $display("FAIL %s q: got %h expected %h", e.name, q, e.q);
                end
                if (e.cyc == cycle) begin
                    checks++;
                    if (dut.state === e.st) passed++;
                    else $display("FAIL %s state: got %h expected %h", e.name, dut.state, e.st);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        rst  = 1'b0;
        we   = 1'b0;
        data = '0;
        m    = 128'd1;

        drive(1'b0, 1'b0, '0, "reset_hold", 128'd1);
        drive(1'b1, 1'b0, '0, "first_step", 128'd1 << 16);
        drive(1'b1, 1'b1, D1, "load_8888", D1);
        drive(1'b1, 1'b0, rnd128(), "step_02aa", {D1[111:0], 16'h02AA});
        drive(1'b1, 1'b1, '0, "load_zero", 128'd1);
        drive(1'b1, 1'b0, rnd128(), "zero_step1", 128'd1 << 16);
        drive(1'b1, 1'b0, rnd128(), "zero_step2", 128'd1 << 32);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, D2, "we_hold", D2);
        run_free(100, "free_run");

        // Let the monitor consume the last step, then assert reset mid-high-phase.
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m   = 128'd1;
        push(cycle, "async_reset", 128'd1);

        drive(1'b0, 1'b1, D2, "reset_over_load", 128'd1);
        drive(1'b1, 1'b0, rnd128(), "post_reset_step", 128'd1 << 16);
        run_free(30, "post_reset_seq");

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: %0d expectations left, required 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
